// File: rtl/om_pkg.sv
// Shared types, digit encodings and digit helpers for the online-multiplier
// residual-adder sequencer.
package om_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INIT,
    RECUR,
    DRAIN,
    DONE
  } om_ctrl_state_t;

  // Signed digit {p,n}, value p-n; 2'b11 carries no weight and behaves as zero.
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;

  function automatic logic dig_is_neg(input logic [1:0] d);
    return d == DIG_NEG;
  endfunction

  function automatic logic dig_is_nz(input logic [1:0] d);
    return (d == DIG_POS) || (d == DIG_NEG);
  endfunction

endpackage

// File: rtl/om_step_counter.sv
// Step index counter for om_ctrl: synchronous clear, count enable and the
// terminal compares that end the INIT, RECUR and DRAIN phases.
module om_step_counter #(
  parameter int N     = 8,
  parameter int DELTA = 3,
  parameter int CW    = $clog2(N + DELTA)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          init_last_o,
  output logic          recur_last_o,
  output logic          drain_last_o
);

  localparam logic [CW-1:0] K_INIT_LAST  = CW'(DELTA - 1);
  localparam logic [CW-1:0] K_RECUR_LAST = CW'(N - 1);
  localparam logic [CW-1:0] K_DRAIN_LAST = CW'(N + DELTA - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: next-state logic uses blocking '=' with a default first so no latch
  // is inferred; the register below is the only place state changes, with '<='.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign init_last_o  = (cnt_q == K_INIT_LAST);
  assign recur_last_o = (cnt_q == K_RECUR_LAST);
  assign drain_last_o = (cnt_q == K_DRAIN_LAST);

endmodule

// File: rtl/om_ctrl.sv
// Sequencer for the shared 4:2 carry-save residual adder of the online multiplier.
// Optional OM_CTRL_ABORT_EN adds an abort input that returns to IDLE with a clear.
module om_ctrl
  import om_pkg::*;
#(
  parameter int N     = 8,
  parameter int DELTA = 3,
  parameter int CW    = $clog2(N + DELTA)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [1:0]    x_dig,
  input  logic [1:0]    y_dig,
`ifdef OM_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          in_ready,
  output logic          csa_clr,
  output logic          csa_en,
  output logic          shift_en,
  output logic          sel_x,
  output logic          sel_y,
  output logic          cin1,
  output logic          cin2,
  output logic          out_valid,
  output logic [CW-1:0] step,
  output logic          busy,
  output logic          done
);

  om_ctrl_state_t state_q, state_d;

  logic abort_act;
  logic fire;
  logic cnt_clr, cnt_en;
  logic init_last, recur_last, drain_last;

`ifdef OM_CTRL_ABORT_EN
  assign abort_act = abort && (state_q != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // A digit pair is consumed only in the handshake phases; abort wins over it.
  assign fire    = in_valid && !abort_act && ((state_q == INIT) || (state_q == RECUR));
  assign cnt_clr = (state_q == CLEAR) || (state_q == DONE) || abort_act;
  assign cnt_en  = fire || (state_q == DRAIN);

  om_step_counter #(
    .N     (N),
    .DELTA (DELTA),
    .CW    (CW)
  ) u_step_counter (
    .clk          (clk),
    .nReset       (nReset),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .cnt_o        (step),
    .init_last_o  (init_last),
    .recur_last_o (recur_last),
    .drain_last_o (drain_last)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_act) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = CLEAR;
        CLEAR:   state_d = INIT;
        INIT:    if (fire && init_last) state_d = RECUR;
        RECUR:   if (fire && recur_last) state_d = DRAIN;
        DRAIN:   if (drain_last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    csa_clr   = 1'b0;
    csa_en    = 1'b0;
    shift_en  = 1'b0;
    sel_x     = 1'b0;
    sel_y     = 1'b0;
    cin1      = 1'b0;
    cin2      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      CLEAR: csa_clr = 1'b1;
      INIT, RECUR: begin
        in_ready = 1'b1;
        if (fire) begin
          csa_en    = 1'b1;
          shift_en  = 1'b1;
          sel_x     = dig_is_nz(x_dig);
          sel_y     = dig_is_nz(y_dig);
          cin1      = dig_is_neg(x_dig);
          cin2      = dig_is_neg(y_dig);
          out_valid = (state_q == RECUR);
        end
      end
      // Drain steps run with zero digits so only the shifted residual advances.
      DRAIN: begin
        csa_en    = 1'b1;
        shift_en  = 1'b1;
        out_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    if (abort_act) begin
      in_ready  = 1'b0;
      csa_en    = 1'b0;
      shift_en  = 1'b0;
      sel_x     = 1'b0;
      sel_y     = 1'b0;
      cin1      = 1'b0;
      cin2      = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      csa_clr   = 1'b1;
    end
  end

endmodule

// File: tb/tb_om_ctrl.sv
// Scoreboard bench for om_ctrl: the driver queues expected adder-control events
// as it issues steps, and a negedge monitor compares every event the DUT shows.
module tb_om_ctrl;
  import om_pkg::*;

  localparam int N     = 8;
  localparam int DELTA = 3;
  localparam int CW    = $clog2(N + DELTA);

  logic          clk = 1'b0;
  logic          nReset;
  logic          start;
  logic          in_valid;
  logic [1:0]    x_dig, y_dig;
`ifdef OM_CTRL_ABORT_EN
  logic          abort;
`endif
  logic          in_ready, csa_clr, csa_en, shift_en, sel_x, sel_y;
  logic          cin1, cin2, out_valid, busy, done;
  logic [CW-1:0] step;

  om_ctrl #(.N(N), .DELTA(DELTA)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .start     (start),
    .in_valid  (in_valid),
    .x_dig     (x_dig),
    .y_dig     (y_dig),
`ifdef OM_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .in_ready  (in_ready),
    .csa_clr   (csa_clr),
    .csa_en    (csa_en),
    .shift_en  (shift_en),
    .sel_x     (sel_x),
    .sel_y     (sel_y),
    .cin1      (cin1),
    .cin2      (cin2),
    .out_valid (out_valid),
    .step      (step),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit order: clr en shift selx sely cin1 cin2 ov done ready busy
  logic [10:0] act_outs;
  assign act_outs = {csa_clr, csa_en, shift_en, sel_x, sel_y, cin1, cin2,
                     out_valid, done, in_ready, busy};

  typedef struct packed {
    int          cyc;
    int          k;
    logic [10:0] outs;
    logic [CW-1:0] step;
    logic        chk_step;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic nz(input logic [1:0] d);
    return (d == 2'b10) || (d == 2'b01);
  endfunction

  function automatic exp_t mk(input int c, input int k, input logic [10:0] o,
                              input int st, input logic cs);
    exp_t e;
    e.cyc = c; e.k = k; e.outs = o; e.step = CW'(st); e.chk_step = cs;
    return e;
  endfunction

  always @(negedge clk) begin
    if (nReset && (csa_clr || csa_en || out_valid || done)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got outs=%b at cyc %0d, required no event", act_outs, cyc);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("event_cycle_k%0d", mon_e.k), cyc, mon_e.cyc);
        check($sformatf("outs_k%0d", mon_e.k), 32'(act_outs), 32'(mon_e.outs));
        if (mon_e.chk_step) check($sformatf("step_k%0d", mon_e.k), 32'(step), 32'(mon_e.step));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; a negative index disables the corresponding event.
  task automatic run_op(input logic [2*N-1:0] xv, input logic [2*N-1:0] yv,
                        input int stall_k, input int stall_len, input int rst_k,
                        input int abort_k, input bit start_in_recur, input bit start_in_done);
    int s, extra, n, c;
    logic [1:0] xd, yd;
    extra = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    sb.push_back(mk(s, -1, 11'b100_0000_0001, 0, 1'b1));
    for (int k = 0; k < N; k++) begin
      if (k == stall_k) begin
        in_valid = 1'b0;
        repeat (stall_len) tick();
        extra += stall_len;
      end
      xd = xv[2*k +: 2];
      yd = yv[2*k +: 2];
      c  = s + 1 + k + extra;
      if (k == rst_k) begin
        nReset = 1'b0;
        #1;
        check("reset_outs", 32'(act_outs), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        tick();
        tick();
        nReset   = 1'b1;
        in_valid = 1'b0;
        tick();
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_step", 32'(step), 32'd0);
        repeat (3) tick();
        return;
      end
`ifdef OM_CTRL_ABORT_EN
      if (k == abort_k) begin
        x_dig = xd; y_dig = yd; in_valid = 1'b1; abort = 1'b1;
        sb.push_back(mk(c, k, 11'b100_0000_0001, k, 1'b1));
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_to_idle_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        return;
      end
`endif
      x_dig = xd; y_dig = yd; in_valid = 1'b1;
      sb.push_back(mk(c, k, {1'b0, 1'b1, 1'b1, nz(xd), nz(yd), xd == 2'b01, yd == 2'b01,
                             k >= DELTA, 1'b0, 1'b1, 1'b1}, k, 1'b1));
      if (start_in_recur && k == DELTA + 1) start = 1'b1;
      n = 0;
      while (!in_ready && n < 8) begin
        tick();
        n++;
      end
      check($sformatf("in_ready_k%0d", k), 32'(in_ready), 32'd1);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    x_dig    = DIG_ZERO;
    y_dig    = DIG_ZERO;
    for (int k = N; k < N + DELTA; k++)
      sb.push_back(mk(s + 1 + k + extra, k, 11'b011_0000_1001, k, 1'b1));
    sb.push_back(mk(s + N + DELTA + 1 + extra, 99, 11'b000_0000_0101, 0, 1'b0));
    if (start_in_done) begin
      n = 0;
      while (cyc < s + N + DELTA + 1 + extra && n < 40) begin
        tick();
        n++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("op_returns_idle", 32'(busy), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nReset   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    x_dig    = DIG_ZERO;
    y_dig    = DIG_ZERO;
`ifdef OM_CTRL_ABORT_EN
    abort    = 1'b0;
`endif
    #3;
    check("reset_state_outs", 32'(act_outs), 32'd0);
    check("reset_state_step", 32'(step), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    tick();
    check("idle_after_reset", 32'(act_outs), 32'd0);

    // x=+1, y=-1 every step, in_valid held
    run_op({N{DIG_POS}}, {N{DIG_NEG}}, -1, 0, -1, -1, 1'b0, 1'b0);
    // mixed digits incl. 2'b11, 2-cycle stall at k=4
    run_op({2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10},
           {2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01},
           4, 2, -1, -1, 1'b0, 1'b0);
    // start pulses in RECUR and in DONE must be ignored
    run_op({N{DIG_NEG}}, {N{DIG_POS}}, -1, 0, -1, -1, 1'b1, 1'b1);
    // asynchronous reset in the middle of RECUR
    run_op({N{DIG_POS}}, {N{DIG_POS}}, -1, 0, 5, -1, 1'b0, 1'b0);
`ifdef OM_CTRL_ABORT_EN
    run_op({N{DIG_POS}}, {N{DIG_NEG}}, -1, 0, -1, 6, 1'b0, 1'b0);
`endif
    run_op({2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00},
           {N{DIG_NEG}}, -1, 0, -1, -1, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/om_ctrl.md
# om_ctrl

Sequencing controller for the shared 4:2 carry-save residual adder of the online multiplier recurrence. It accepts a signed-digit operand pair per step via a valid/ready handshake and walks the recurrence through clear, initialisation (online delay), recurrence and drain phases. It drives the adder's load/clear enables, operand selects and the two carry-ins, and flags which steps produce an output digit.

## Interface
- N, 8, operand/result length in digits; N > DELTA required
- DELTA, 3, online delay in steps; ≥ 1
- CW, $clog2(N+DELTA), step counter width
- clk  in  1  rising-edge clock
- nReset  in  1  asynchronous, active-low reset
- start  in  1  begin an operation; sampled only in IDLE
- in_valid  in  1  x_dig/y_dig hold the next digit pair
- x_dig  in  2  signed digit {p,n}, value p−n; 2'b11 treated as 0
- y_dig  in  2  signed digit, same encoding
- in_ready  out  1  controller will consume a digit pair this cycle
- csa_clr  out  1  clear Ws/Wc registers
- csa_en  out  1  load adder result into Ws/Wc
- shift_en  out  1  adder uses 2·w (shifted residual) this step
- sel_x  out  1  add x-term (x_dig · CA(Y)) this step
- sel_y  out  1  add y-term (y_dig · CA(X)) this step
- cin1  out  1  x-term negated (x_dig = −1)
- cin2  out  1  y-term negated (y_dig = −1)
- out_valid  out  1  this step produces an output digit
- step  out  CW  current step index k = j + DELTA
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, INIT, RECUR, DRAIN, DONE.
- IDLE: start=1 → CLEAR. start in any other state ignored.
- CLEAR: one cycle, csa_clr=1, step←0 → INIT.
- INIT (k = 0..DELTA−1): in_ready=1; step fires on in_valid. On fire: csa_en=1, shift_en=1, out_valid=0, step++. After k=DELTA−1 fires → RECUR.
- RECUR (k = DELTA..N−1): same handshake, out_valid=1 on fire. After k=N−1 fires → DRAIN.
- DRAIN (k = N..N+DELTA−1): in_ready=0, one step every cycle, digits forced to 0 (sel_x=sel_y=cin1=cin2=0), csa_en=1, out_valid=1. After k=N+DELTA−1 → DONE.
- DONE: done=1 one cycle, step←0 → IDLE.
- Per fired step: sel_x = x_dig∈{+1,−1}; cin1 = (x_dig==−1); likewise sel_y/cin2 from y_dig. Zero digit → select 0, cin 0.
- in_valid=0 in INIT/RECUR: stall; csa_en, shift_en, out_valid, sel/cin all 0; step holds.
- Total fired steps = N+DELTA; out_valid asserted exactly N times.

## Timing
- Reset: state IDLE, step=0, every output 0 (incl. in_ready, busy, done).
- Step outputs combinational from state and in_valid/digits; state/step registered. Adder loads on the edge ending the fire cycle.
- in_valid held continuously: start sampled at edge 0 → CLEAR cycle 1, INIT 1+1..1+DELTA, RECUR to 1+N, DRAIN to 1+N+DELTA, done in cycle N+DELTA+2 (13 for defaults).
- nReset mid-operation: immediate return to reset values; no done.
- start high in DONE cycle ignored; new start must be sampled in IDLE.

## Configuration
- OM_CTRL_ABORT_EN defined: extra input abort (1 bit). abort=1 in any non-IDLE state → next state CLEAR-free IDLE, with csa_clr=1 in the abort cycle, csa_en=0, no done. abort has priority over a fire in the same cycle.
- Undefined: no abort port; operations always run to DONE.

## Structure
- Package om_pkg: state enum om_ctrl_state_t; digit constants DIG_ZERO=2'b00, DIG_POS=2'b10, DIG_NEG=2'b01; helper function dig_is_neg.
- One sub-module: om_step_counter (CW-bit counter, sync clear, enable, terminal-compare outputs for DELTA−1, N−1, N+DELTA−1).

## Test plan
- Reset: nReset=0 mid-RECUR → all outputs 0, busy=0 same cycle; release, state IDLE.
- Defaults, in_valid=1, x=+1,y=−1 every step: csa_clr cycle 1, csa_en cycles 2–12, out_valid cycles 5–12 (8 pulses), cin2=1 & cin1=0 in cycles 2–9, done cycle 13.
- Stall: drop in_valid for 2 cycles at k=4 → step holds at 4, no csa_en/out_valid, done delayed to cycle 15.
- Digit 2'b11 on x: sel_x=0, cin1=0 for that step.
- start asserted during RECUR and during DONE → ignored; exactly one done pulse.
- OM_CTRL_ABORT_EN: abort at k=6 → csa_clr=1 that cycle, IDLE next, done never asserted; following start runs normally.
